// File: rtl/fpu_types_pkg.sv
// Shared FPU types: RISC-V rounding modes, fflags layout and special-value encodings.
package fpu_types_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_t;

  // Bit order matches the fflags CSR: {NV,DZ,OF,UF,NX}
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  // Magnitude fields {exp, man} of the largest finite value, right-aligned in 64 bits
  function automatic logic [63:0] fp_max_finite(input int exp_w, input int man_w);
    return ((((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1));
  endfunction

  function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w);
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fpu_lzc #(
  parameter int W = 32
) (
  input  logic [W-1:0]       a,
  output logic [$clog2(W):0] cnt
);

  localparam int CW = $clog2(W) + 1;

  // Scanning upward lets the highest set bit win the last assignment
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (a[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_icvt_pipe.sv
// Three-stage integer-to-float converter with valid/ready flow control.
// Define FPU_ICVT_FLAGS_EN to build the OF/NX flag datapath; otherwise out_flags is 0.
module fpu_icvt_pipe
  import fpu_types_pkg::*;
#(
  parameter int INT_W = 32,
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INT_W-1:0]       in_int,
  input  logic                   in_signed,
  input  logic [2:0]             in_rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_float,
  output logic [4:0]             out_flags
);

  localparam int FW  = 1 + EXP_W + MAN_W;
  localparam int LZW = $clog2(INT_W) + 1;
  localparam int XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam int SW  = INT_W + MAN_W;
  localparam logic [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 2);
  localparam logic [63:0]   MAXF_64 = fp_max_finite(EXP_W, MAN_W);
  localparam logic [63:0]   INF_64  = fp_inf(EXP_W, MAN_W);
  localparam logic [FW-2:0] MAXF    = MAXF_64[FW-2:0];
  localparam logic [FW-2:0] INF     = INF_64[FW-2:0];

  function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                    input logic lsb, input logic g, input logic s);
    case (rm)
      RM_RNE:  return g & (s | lsb);
      RM_RMM:  return g;
      RM_RUP:  return (g | s) & ~sign;
      RM_RDN:  return (g | s) & sign;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic sat_to_inf(input logic [2:0] rm, input logic sign);
    case (rm)
      RM_RNE, RM_RMM: return 1'b1;
      RM_RUP:         return ~sign;
      RM_RDN:         return sign;
      default:        return 1'b0;
    endcase
  endfunction

  logic en_p1, en_p2, en_p3;
  logic vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q, vld_p3_d, vld_p3_q;

  logic             sign_p1_d, sign_p1_q;
  logic [INT_W-1:0] mag_p1_d, mag_p1_q;
  logic [2:0]       rm_p1_d, rm_p1_q;

  logic [LZW-1:0]   lzc_p1;
  logic [INT_W-1:0] norm_full;
  logic             sign_p2_d, sign_p2_q;
  logic             zero_p2_d, zero_p2_q;
  logic [INT_W-2:0] norm_p2_d, norm_p2_q;
  logic [XW-1:0]    exp_p2_d, exp_p2_q;
  logic [2:0]       rm_p2_d, rm_p2_q;

  logic [SW-1:0]    frac;
  logic [MAN_W-1:0] man_t, man_r;
  logic [MAN_W:0]   man_inc;
  logic             g, s, rup, ovf;
  logic [XW-1:0]    exp_b;
  logic [FW-1:0]    res;
  logic [FW-1:0]    out_float_d, out_float_q;

  // Each stage advances when empty or when its successor advances
  always_comb begin
    en_p3    = !vld_p3_q || out_ready;
    en_p2    = !vld_p2_q || en_p3;
    en_p1    = !vld_p1_q || en_p2;
    vld_p1_d = en_p1 ? in_valid : vld_p1_q;
    vld_p2_d = en_p2 ? vld_p1_q : vld_p2_q;
    vld_p3_d = en_p3 ? vld_p2_q : vld_p3_q;
  end

  assign in_ready  = en_p1;
  assign out_valid = vld_p3_q;
  assign out_float = out_float_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      out_float_q <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      vld_p3_q    <= vld_p3_d;
      out_float_q <= out_float_d;
    end
  end

  // ---- stage p1: sign and magnitude ----
  always_comb begin
    sign_p1_d = sign_p1_q;
    mag_p1_d  = mag_p1_q;
    rm_p1_d   = rm_p1_q;
    if (en_p1 && in_valid) begin
      sign_p1_d = in_signed & in_int[INT_W-1];
      mag_p1_d  = sign_p1_d ? ('0 - in_int) : in_int;
      rm_p1_d   = in_rm;
    end
  end

  // ---- stage p2: normalise ----
  fpu_lzc #(.W(INT_W)) u_lzc (
    .a   (mag_p1_q),
    .cnt (lzc_p1)
  );

  always_comb begin
    norm_full = mag_p1_q << lzc_p1;
    sign_p2_d = sign_p2_q;
    zero_p2_d = zero_p2_q;
    norm_p2_d = norm_p2_q;
    exp_p2_d  = exp_p2_q;
    rm_p2_d   = rm_p2_q;
    if (en_p2 && vld_p1_q) begin
      sign_p2_d = sign_p1_q;
      zero_p2_d = !norm_full[INT_W-1];
      norm_p2_d = norm_full[INT_W-2:0];
      exp_p2_d  = XW'(INT_W - 1) - XW'(lzc_p1);
      rm_p2_d   = rm_p1_q;
    end
  end

  // ---- stage p3: round, saturate, pack ----
  always_comb begin
    frac    = {norm_p2_q, {(MAN_W + 1){1'b0}}};
    man_t   = frac[SW-1 -: MAN_W];
    g       = frac[SW-1-MAN_W];
    s       = |frac[SW-2-MAN_W:0];
    rup     = round_up(rm_p2_q, sign_p2_q, man_t[0], g, s);
    man_inc = {1'b0, man_t} + (MAN_W + 1)'(1);
    man_r   = rup ? man_inc[MAN_W-1:0] : man_t;
    exp_b   = exp_p2_q + BIAS + XW'(rup & man_inc[MAN_W]);
    ovf     = exp_b > EXP_MAX;
    if (zero_p2_q)
      res = '0;
    else if (ovf)
      res = {sign_p2_q, sat_to_inf(rm_p2_q, sign_p2_q) ? INF : MAXF};
    else
      res = {sign_p2_q, exp_b[EXP_W-1:0], man_r};
    out_float_d = (en_p3 && vld_p2_q) ? res : out_float_q;
  end

  always_ff @(posedge CLK) begin
    sign_p1_q <= sign_p1_d;
    mag_p1_q  <= mag_p1_d;
    rm_p1_q   <= rm_p1_d;
    sign_p2_q <= sign_p2_d;
    zero_p2_q <= zero_p2_d;
    norm_p2_q <= norm_p2_d;
    exp_p2_q  <= exp_p2_d;
    rm_p2_q   <= rm_p2_d;
  end

`ifdef FPU_ICVT_FLAGS_EN
  fflags_t flags_d, flags_q;

  // Saturation is always inexact, even from an exact power of two
  always_comb begin
    flags_d = flags_q;
    if (en_p3 && vld_p2_q) begin
      flags_d = '0;
      if (!zero_p2_q) begin
        flags_d.of = ovf;
        flags_d.nx = ovf | g | s;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign out_flags = flags_q;
`else
  assign out_flags = '0;
`endif

endmodule
